// File: rtl/md_seq.sv
// Multiply/divide sequencer: computes the HI/LO result at issue, then holds busy
// for a fixed latency before committing it to the architectural HI/LO registers.
module md_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [31:0]         r_pend_hi;
    logic [31:0]         r_pend_lo;
    logic                w_load;
    logic                w_commit;
    logic                w_is_md;
    logic signed [63:0]  w_smul;
    logic [63:0]         w_umul;
    logic [31:0]         w_divisor;
    logic signed [31:0]  w_sq;
    logic signed [31:0]  w_sr;
    logic [31:0]         w_res_hi;
    logic [31:0]         w_res_lo;

    assign w_is_md   = start && (op <= 3'd3);
    assign w_smul    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul    = {32'd0, a} * {32'd0, b};
    // Divisor is forced non-zero so the divide never produces X; b == 0 keeps HI/LO.
    assign w_divisor = (b == 32'd0) ? 32'd1 : b;

    always_comb begin
        w_sq = $signed(a) / $signed(w_divisor);
        w_sr = $signed(a) % $signed(w_divisor);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            w_sq = 32'sh8000_0000;
            w_sr = 32'sd0;
        end
    end

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (op)
            3'd0: {w_res_hi, w_res_lo} = w_smul;
            3'd1: {w_res_hi, w_res_lo} = w_umul;
            3'd2: if (b != 32'd0) {w_res_hi, w_res_lo} = {w_sr, w_sq};
            3'd3: if (b != 32'd0) {w_res_hi, w_res_lo} = {a % w_divisor, a / w_divisor};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: if (w_is_md) begin
                w_load      = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: if (r_cnt == CW'(1)) begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            if (w_load) begin
                r_cnt     <= (op[1]) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // Moves to HI/LO are only honoured in IDLE, so they never race a commit.
            if (w_commit) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else if (r_state == IDLE && start && op == 3'd4) begin
                r_hi <= a;
            end else if (r_state == IDLE && start && op == 3'd5) begin
                r_lo <= a;
            end
        end
    end

    assign busy  = (r_state == RUN);
    assign stall = md_in_d && (busy || w_is_md);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: a vector table of operations with expected latency
// and HI/LO, plus hand sequences for ignored starts, stall and mid-run reset.
module tb_md_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_in_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total;
    int n_pass;

    md_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_in_d(md_in_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one start pulse and count the busy cycles that follow (bounded).
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int bad;
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0};
        vecs[5]  = '{3'd5, 32'hCAFEF00D, 32'd0,        32'h12345678, 32'hCAFEF00D, 0};
        vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[7]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[9]  = '{3'd6, 32'd5,        32'd9,        32'd1,        32'hFFFFFFFD, 0};
        vecs[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[11] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[12] = '{3'd2, 32'd5,        32'd0,        32'hFFFFFFFE, 32'h00000001, 10};

        n_total = 0; n_pass = 0;
        start = 1'b0; op = 3'd0; a = '0; b = '0; md_in_d = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end

        // A second start during RUN must not disturb the first result.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
        cyc++;
        @(negedge clk);
        start = 1'b0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("ignore_cycles", cyc, 32'd5);
        chk("ignore_hi", hi, 32'd0);
        chk("ignore_lo", lo, 32'd12);

        // Stall held through a DIV, released in the first IDLE cycle.
        @(negedge clk);
        md_in_d = 1'b1; start = 1'b1; op = 3'd2; a = 32'd9; b = 32'd2;
        #1 chk("stall_start", {31'd0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; bad = 0;
        while (busy && cyc < 100) begin
            if (stall !== 1'b1) bad++;
            cyc++;
            @(negedge clk);
        end
        chk("stall_busy_cycles", bad, 32'd0);
        chk("stall_div_cycles", cyc, 32'd10);
        chk("stall_idle", {31'd0, stall}, 32'd0);
        chk("stall_div_lo", lo, 32'd4);
        chk("stall_div_hi", hi, 32'd1);
        md_in_d = 1'b0;

        // Reset in cycle 3 of a MULT aborts asynchronously.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        md_in_d = 1'b1;
        #1 chk("rst_stall_nostart", {31'd0, stall}, 32'd0);
        md_in_d = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_op(3'd0, 32'd4, 32'd5, cyc);
        chk("post_rst_cycles", cyc, 32'd5);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
